instr_fetch_queue: RTL and testbench

//  Fetch stage upstream of the decoder, downstream of the 32-bit instruction memory block.

---
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Purpose: fetch stage that owns the PC, issues sequential reads and buffers {instr, pc} for decode (optional IFQ_PERF_CNT_EN bubble counter).
// Latency: request in cycle N reaches out_valid in cycle N+2 on an empty queue; one word per cycle steady state.
// Backpressure: requests are issued only while queued plus in-flight words fit in DEPTH; out_ready=0 stalls fetch.
module instr_fetch_queue #(
    parameter int AWIDTH = 6,
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_instr,
    output logic [AWIDTH-1:0] out_pc
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [15:0]       perf_bubble_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AWIDTH-1:0] r_pc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic              r_inflight;
    logic [AWIDTH-1:0] r_inflight_pc;
    logic [DWIDTH-1:0] r_instr [DEPTH];
    logic [AWIDTH-1:0] r_epc   [DEPTH];

    logic [CW:0]       w_used;
    logic              w_push;
    logic              w_pop;

    // In-flight read holds a slot so the FIFO can never overflow.
    assign w_used   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign mem_req  = rst_n & ~halt & ~redirect_valid & (w_used < (CW+1)'(DEPTH));
    assign mem_addr = r_pc;

    assign out_valid = (r_count != '0);
    assign out_instr = out_valid ? r_instr[r_rd_ptr] : '0;
    assign out_pc    = out_valid ? r_epc[r_rd_ptr]   : '0;

    assign w_push = r_inflight & ~redirect_valid;
    assign w_pop  = out_valid & out_ready & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_addr;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= mem_req;
            if (mem_req) begin
                r_pc          <= r_pc + 1'b1;
                r_inflight_pc <= r_pc;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= mem_rdata;
            r_epc[r_wr_ptr]   <= r_inflight_pc;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (redirect_valid) begin
            r_bubble_cnt <= '0;
        end else if (!out_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: vector table, directed corner sequences and a randomized run against a queue model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [5:0]  redirect_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
`ifdef IFQ_PERF_CNT_EN
    logic [15:0] perf_bubble_cnt;
`endif

    instr_fetch_queue #(.AWIDTH(6), .DWIDTH(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, word = 0x1000_0000 + address.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= 32'h1000_0000 + {26'd0, mem_addr};
    end

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  pc;
    } ent_t;

    typedef struct {
        bit       h;
        bit       r;
        bit [5:0] ra;
        bit       rdy;
        bit       e_req;
        bit [5:0] e_addr;
        bit       e_vld;
        bit [5:0] e_pc;
    } vec_t;

    int n_err = 0;
    int n_chk = 0;

    ent_t        m_q[$];
    int          m_pc;
    bit          m_inf;
    int          m_inf_pc;
    int          m_bub;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc = 0;
        m_inf = 0;
        m_inf_pc = 0;
        m_bub = 0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", {26'd0, out_pc}, 32'd0);
`ifdef IFQ_PERF_CNT_EN
        chk("rst_perf", {16'd0, perf_bubble_cnt}, 32'd0);
`endif
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One cycle: drive inputs, compare with the model, then advance the model across the edge.
    task automatic step(input bit h, input bit r, input bit [5:0] ra, input bit rdy);
        bit e_req;
        ent_t e;
        @(negedge clk);
        halt = h;
        redirect_valid = r;
        redirect_addr = ra;
        out_ready = rdy;
        #1;
        e_req = !h && !r && ((m_q.size() + int'(m_inf)) < 4);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        chk("mem_addr", {26'd0, mem_addr}, m_pc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            chk("out_instr", out_instr, m_q[0].instr);
            chk("out_pc", {26'd0, out_pc}, {26'd0, m_q[0].pc});
        end
`ifdef IFQ_PERF_CNT_EN
        chk("perf_cnt", {16'd0, perf_bubble_cnt}, m_bub);
        if (r) m_bub = 0;
        else if (m_q.size() == 0 && m_bub != 16'hFFFF) m_bub++;
`endif
        if (r) begin
            m_q.delete();
            m_inf = 0;
            m_pc = int'(ra);
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (m_inf) begin
                e.pc = 6'(m_inf_pc);
                e.instr = 32'h1000_0000 + m_inf_pc;
                m_q.push_back(e);
            end
            m_inf = e_req;
            if (e_req) begin
                m_inf_pc = m_pc;
                m_pc = (m_pc + 1) % 64;
            end
        end
    endtask

    vec_t vt[19];
    int   nreq;
    bit   found;

    initial begin
        vt[0]  = '{0, 0, 6'h00, 1, 1, 6'h00, 0, 6'h00};
        vt[1]  = '{0, 0, 6'h00, 1, 1, 6'h01, 0, 6'h00};
        vt[2]  = '{0, 0, 6'h00, 1, 1, 6'h02, 1, 6'h00};
        vt[3]  = '{0, 0, 6'h00, 1, 1, 6'h03, 1, 6'h01};
        vt[4]  = '{1, 0, 6'h00, 1, 0, 6'h04, 1, 6'h02};
        vt[5]  = '{1, 0, 6'h00, 1, 0, 6'h04, 1, 6'h03};
        vt[6]  = '{1, 0, 6'h00, 1, 0, 6'h04, 0, 6'h00};
        vt[7]  = '{0, 0, 6'h00, 1, 1, 6'h04, 0, 6'h00};
        vt[8]  = '{0, 0, 6'h00, 1, 1, 6'h05, 0, 6'h00};
        vt[9]  = '{0, 0, 6'h00, 1, 1, 6'h06, 1, 6'h04};
        vt[10] = '{0, 1, 6'h3E, 1, 0, 6'h07, 1, 6'h05};
        vt[11] = '{0, 0, 6'h00, 1, 1, 6'h3E, 0, 6'h00};
        vt[12] = '{0, 0, 6'h00, 1, 1, 6'h3F, 0, 6'h00};
        vt[13] = '{0, 0, 6'h00, 1, 1, 6'h00, 1, 6'h3E};
        vt[14] = '{0, 0, 6'h00, 1, 1, 6'h01, 1, 6'h3F};
        vt[15] = '{0, 0, 6'h00, 0, 1, 6'h02, 1, 6'h00};
        vt[16] = '{0, 0, 6'h00, 0, 1, 6'h03, 1, 6'h00};
        vt[17] = '{0, 0, 6'h00, 0, 0, 6'h04, 1, 6'h00};
        vt[18] = '{0, 0, 6'h00, 0, 0, 6'h04, 1, 6'h00};

        reset_dut();
        for (int i = 0; i < 19; i++) begin
            step(vt[i].h, vt[i].r, vt[i].ra, vt[i].rdy);
            chk($sformatf("vec%0d_req", i), {31'd0, mem_req}, {31'd0, vt[i].e_req});
            chk($sformatf("vec%0d_addr", i), {26'd0, mem_addr}, {26'd0, vt[i].e_addr});
            chk($sformatf("vec%0d_vld", i), {31'd0, out_valid}, {31'd0, vt[i].e_vld});
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d_pc", i), {26'd0, out_pc}, {26'd0, vt[i].e_pc});
                chk($sformatf("vec%0d_instr", i), out_instr, 32'h1000_0000 + {26'd0, vt[i].e_pc});
            end
        end

        // Stalled decoder: exactly DEPTH requests, then an in-order gapless drain.
        reset_dut();
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 6'h00, 0);
            if (mem_req) nreq++;
        end
        chk("stall_req_count", nreq, 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 6'h00, 1);
            chk("drain_vld", {31'd0, out_valid}, 32'd1);
            chk("drain_pc", {26'd0, out_pc}, i);
        end
        for (int i = 0; i < 8; i++) step(0, 0, 6'h00, 0);
        chk("full_vld", {31'd0, out_valid}, 32'd1);

        // Asynchronous reset pulse with the queue full.
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_mem_addr", {26'd0, mem_addr}, 32'd0);
        chk("arst_out_instr", out_instr, 32'd0);
        chk("arst_out_pc", {26'd0, out_pc}, 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(0, 0, 6'h00, 1);
        step(0, 0, 6'h00, 1);
        step(0, 0, 6'h00, 1);
        chk("refetch_vld", {31'd0, out_valid}, 32'd1);
        chk("refetch_pc", {26'd0, out_pc}, 32'd0);
`ifdef IFQ_PERF_CNT_EN
        chk("refetch_perf", {16'd0, perf_bubble_cnt}, 32'd2);
`endif

        // Redirect while three words are queued.
        reset_dut();
        for (int i = 0; i < 4; i++) step(0, 0, 6'h00, 0);
        chk("pre_redir_vld", {31'd0, out_valid}, 32'd1);
        step(0, 1, 6'h20, 1);
        step(0, 0, 6'h00, 1);
        chk("post_redir_vld", {31'd0, out_valid}, 32'd0);
        chk("post_redir_addr", {26'd0, mem_addr}, 32'h20);
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            step(0, 0, 6'h00, 1);
            if (out_valid) begin
                found = 1;
                chk("redir_first_pc", {26'd0, out_pc}, 32'h20);
            end
        end
        chk("redir_delivered", {31'd0, found}, 32'd1);

        // Redirect during halt loads the PC but waits for release.
        step(1, 1, 6'h10, 1);
        step(1, 0, 6'h00, 1);
        chk("halt_redir_req", {31'd0, mem_req}, 32'd0);
        chk("halt_redir_addr", {26'd0, mem_addr}, 32'h10);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) == 0, ($urandom % 20) == 0, 6'($urandom), ($urandom % 4) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
